// File: rtl/tpx3_stream_merger.sv
// N-channel FWFT readout merger: bounded-burst round-robin over enabled source FIFOs,
// one registered FWFT output word, and per-channel saturating pop counters.
module tpx3_stream_merger #(
  parameter int NCH       = 10,
  parameter int DW        = 32,
  parameter int BURST_MAX = 16,
  parameter int CNT_WIDTH = 32,
  parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST,
  input  logic [NCH-1:0]           CH_ENABLE,
  input  logic [NCH-1:0]           IN_EMPTY,
  input  logic [NCH*DW-1:0]        IN_DATA,
  output logic [NCH-1:0]           IN_READ,
  input  logic                     OUT_READ,
  output logic                     OUT_EMPTY,
  output logic [DW-1:0]            OUT_DATA,
  output logic                     GRANT_VALID,
  output logic [CHW-1:0]           GRANT_CH,
  input  logic                     CNT_CLEAR,
  output logic [NCH*CNT_WIDTH-1:0] WORD_CNT
);

  localparam logic [0:0]     IDLE       = 1'b0;
  localparam logic [0:0]     BURST      = 1'b1;
  localparam logic [CHW-1:0] LAST_CH    = CHW'(NCH - 1);
  localparam logic [8:0]     BURST_LAST = 9'(BURST_MAX);

  logic [0:0]           state;
  logic [CHW-1:0]       ptr;
  logic [CHW-1:0]       ch;
  logic [7:0]           bcnt;
  logic [DW-1:0]        data_p0;
  logic                 vld_p0;
  logic [CNT_WIDTH-1:0] cnt [NCH];
  logic [DW-1:0]        in_word [NCH];

  logic                 found;
  logic [CHW-1:0]       found_ch;
  logic [CHW-1:0]       cidx;
  int                   sidx;
  logic                 slot_free;
  logic                 ch_ok;
  logic                 pop;
  logic                 last_pop;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] c);
    return (c == LAST_CH) ? '0 : c + 1'b1;
  endfunction

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign in_word[k]                          = IN_DATA[k*DW +: DW];
    assign WORD_CNT[k*CNT_WIDTH +: CNT_WIDTH] = cnt[k];
  end

  // Round-robin search starting at ptr, wrapping modulo NCH
  always_comb begin
    found    = 1'b0;
    found_ch = '0;
    sidx     = 0;
    cidx     = '0;
    for (int i = 0; i < NCH; i++) begin
      sidx = int'(ptr) + i;
      if (sidx >= NCH) sidx = sidx - NCH;
      cidx = CHW'(sidx);
      if (!found && CH_ENABLE[cidx] && !IN_EMPTY[cidx]) begin
        found    = 1'b1;
        found_ch = cidx;
      end
    end
  end

  assign slot_free = ~vld_p0 | OUT_READ;
  assign ch_ok     = CH_ENABLE[ch] & ~IN_EMPTY[ch];
  assign pop       = (state == BURST) & slot_free & ch_ok & ~BUS_RST;
  assign last_pop  = pop & (({1'b0, bcnt} + 9'd1) == BURST_LAST);

  always_comb begin
    IN_READ = '0;
    if (pop) IN_READ[ch] = 1'b1;
  end

  // Back-pressure only stalls the burst; it ends on quota, empty source or disable
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state <= IDLE;
      ptr   <= '0;
      ch    <= '0;
      bcnt  <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        ch    <= found_ch;
        bcnt  <= '0;
        state <= BURST;
      end
    end else begin
      if (pop) bcnt <= bcnt + 8'd1;
      if (last_pop || !ch_ok) begin
        state <= IDLE;
        ptr   <= next_ch(ch);
      end
    end
  end

  // Stage p0: output register, refilled in the same cycle it is drained
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (pop) begin
      vld_p0  <= 1'b1;
      data_p0 <= in_word[ch];
    end else if (OUT_READ) begin
      vld_p0  <= 1'b0;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    always_ff @(posedge BUS_CLK) begin
      if (BUS_RST || CNT_CLEAR) cnt[k] <= '0;
      else if (IN_READ[k])      cnt[k] <= sat_inc(cnt[k]);
    end
  end

  assign OUT_EMPTY   = ~vld_p0;
  assign OUT_DATA    = data_p0;
  assign GRANT_VALID = (state == BURST);
  assign GRANT_CH    = ch;

endmodule

// File: tb/tb_tpx3_stream_merger.sv
// Scoreboard bench for tpx3_stream_merger: queue-modelled source FIFOs, per-channel
// expected-word queues, and a grant/burst log compared against hand-derived sequences.
module tb_tpx3_stream_merger;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int BM  = 4;
  localparam int CW  = 4;
  localparam int CHW = 2;

  logic              BUS_CLK = 1'b0;
  logic              BUS_RST = 1'b1;
  logic [NCH-1:0]    CH_ENABLE = '1;
  logic [NCH-1:0]    IN_EMPTY = '1;
  logic [NCH*DW-1:0] IN_DATA = '0;
  logic [NCH-1:0]    IN_READ;
  logic              OUT_READ = 1'b0;
  logic              OUT_EMPTY;
  logic [DW-1:0]     OUT_DATA;
  logic              GRANT_VALID;
  logic [CHW-1:0]    GRANT_CH;
  logic              CNT_CLEAR = 1'b0;
  logic [NCH*CW-1:0] WORD_CNT;

  tpx3_stream_merger #(.NCH(NCH), .DW(DW), .BURST_MAX(BM), .CNT_WIDTH(CW)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .CH_ENABLE(CH_ENABLE), .IN_EMPTY(IN_EMPTY),
    .IN_DATA(IN_DATA), .IN_READ(IN_READ), .OUT_READ(OUT_READ), .OUT_EMPTY(OUT_EMPTY),
    .OUT_DATA(OUT_DATA), .GRANT_VALID(GRANT_VALID), .GRANT_CH(GRANT_CH),
    .CNT_CLEAR(CNT_CLEAR), .WORD_CNT(WORD_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] src_q [NCH][$];
  logic [31:0] exp_q [NCH][$];
  int grant_log[$];
  int len_log[$];
  int gap_log[$];
  int cur_len, idle_run, out_cnt;
  int pop_cnt [NCH];
  bit seen_burst;
  logic prev_gv = 1'b0;

  logic              s_gv, s_oe;
  logic [CHW-1:0]    s_gch;
  logic [NCH-1:0]    s_rd;
  logic [DW-1:0]     s_od;
  logic [NCH*CW-1:0] s_cnt;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int c, input int tag, input int i);
    return {c[7:0], tag[7:0], i[15:0]};
  endfunction

  function automatic int cnt_of(input logic [NCH*CW-1:0] v, input int k);
    return int'(v[k*CW +: CW]);
  endfunction

  function automatic bit busy();
    for (int k = 0; k < NCH; k++)
      if (src_q[k].size() > 0 && CH_ENABLE[k]) return 1'b1;
    return !OUT_EMPTY || GRANT_VALID;
  endfunction

  task automatic drive_srcs();
    for (int k = 0; k < NCH; k++) begin
      IN_EMPTY[k] = (src_q[k].size() == 0);
      IN_DATA[k*DW +: DW] = (src_q[k].size() == 0) ? 32'hDEAD_0000 : src_q[k][0];
    end
  endtask

  task automatic load(input int c, input int n, input int tag);
    for (int i = 0; i < n; i++) begin
      src_q[c].push_back(mk(c, tag, i));
      exp_q[c].push_back(mk(c, tag, i));
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    len_log.delete();
    gap_log.delete();
    cur_len = 0;
    idle_run = 0;
    out_cnt = 0;
    seen_burst = 1'b0;
    for (int k = 0; k < NCH; k++) pop_cnt[k] = 0;
  endtask

  // One bus cycle: drive sources, sample at negedge, retire source pops after posedge
  task automatic tick();
    int c;
    drive_srcs();
    @(negedge BUS_CLK);
    s_gv  = GRANT_VALID;
    s_gch = GRANT_CH;
    s_rd  = IN_READ;
    s_oe  = OUT_EMPTY;
    s_od  = OUT_DATA;
    s_cnt = WORD_CNT;
    if (s_rd != '0) check_eq("rd_onehot", int'($onehot0(s_rd)), 1);
    for (int k = 0; k < NCH; k++) begin
      if (s_rd[k] === 1'b1) begin
        check_eq("rd_legal", int'(src_q[k].size() > 0 && CH_ENABLE[k]), 1);
        pop_cnt[k]++;
      end
    end
    if (OUT_READ && s_oe === 1'b0) begin
      out_cnt++;
      c = int'(s_od[31:24]);
      check_eq("out_ch_range", int'(c < NCH), 1);
      if (c < NCH) begin
        check_eq("out_pending", int'(exp_q[c].size() > 0), 1);
        if (exp_q[c].size() > 0) check_eq("out_data", int'(s_od), int'(exp_q[c].pop_front()));
      end
    end
    if (s_gv === 1'b1 && prev_gv !== 1'b1) begin
      grant_log.push_back(int'(s_gch));
      if (seen_burst) gap_log.push_back(idle_run);
      seen_burst = 1'b1;
      cur_len = 0;
    end
    if (s_gv === 1'b1 && s_rd != '0) cur_len++;
    if (s_gv === 1'b0) begin
      if (prev_gv === 1'b1) begin
        len_log.push_back(cur_len);
        idle_run = 0;
      end
      idle_run++;
    end
    prev_gv = s_gv;
    @(posedge BUS_CLK);
    #1;
    for (int k = 0; k < NCH; k++)
      if (s_rd[k] === 1'b1 && src_q[k].size() > 0) void'(src_q[k].pop_front());
  endtask

  // Reset discards the output register, so only words still in the sources remain due
  task automatic do_reset(input int cycles);
    BUS_RST = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_eq("rst_no_read", int'(s_rd), 0);
    end
    BUS_RST = 1'b0;
    for (int k = 0; k < NCH; k++) exp_q[k] = src_q[k];
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while (busy() && n < limit) begin
      tick();
      n++;
    end
    check_eq(tag, int'(busy()), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_len[3];
    int n2, got, n;
    logic [31:0] w0;

    // Reset values
    do_reset(2);
    check_eq("rst_out_empty", int'(OUT_EMPTY), 1);
    check_eq("rst_out_data", int'(OUT_DATA), 0);
    check_eq("rst_grant_valid", int'(GRANT_VALID), 0);
    check_eq("rst_grant_ch", int'(GRANT_CH), 0);
    check_eq("rst_word_cnt", int'(WORD_CNT), 0);
    check_eq("rst_in_read", int'(IN_READ), 0);

    // Single busy channel: bursts 4,4,2, re-granted, one IDLE cycle apart
    clear_logs();
    OUT_READ = 1'b1;
    load(0, 10, 1);
    tick();
    check_eq("t1_lat_idle_gv", int'(s_gv), 0);
    check_eq("t1_lat_idle_rd", int'(s_rd), 0);
    tick();
    check_eq("t1_lat_gv", int'(s_gv), 1);
    check_eq("t1_lat_rd", int'(s_rd), 1);
    check_eq("t1_lat_oe", int'(s_oe), 1);
    tick();
    check_eq("t1_lat_oe2", int'(s_oe), 0);
    check_eq("t1_lat_od", int'(s_od), int'(mk(0, 1, 0)));
    drain("t1_drain", 100);
    e_len = '{4, 4, 2};
    check_eq("t1_nbursts", grant_log.size(), 3);
    check_eq("t1_nlens", len_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++) check_eq("t1_grant", grant_log[i], 0);
    for (int i = 0; i < 3 && i < len_log.size(); i++) check_eq("t1_len", len_log[i], e_len[i]);
    check_eq("t1_ngaps", gap_log.size(), 2);
    for (int i = 0; i < gap_log.size(); i++) check_eq("t1_gap", gap_log[i], 1);
    check_eq("t1_words", out_cnt, 10);
    check_eq("t1_cnt0", cnt_of(WORD_CNT, 0), 10);

    // All channels busy: strict rotation
    do_reset(1);
    clear_logs();
    for (int k = 0; k < NCH; k++) load(k, 8, 2);
    drain("t2_drain", 200);
    check_eq("t2_nbursts", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) check_eq("t2_grant", grant_log[i], i % NCH);
    for (int i = 0; i < len_log.size(); i++) check_eq("t2_len", len_log[i], BM);
    check_eq("t2_words", out_cnt, 32);
    for (int k = 0; k < NCH; k++) check_eq("t2_cnt", cnt_of(WORD_CNT, k), 8);

    // Enable mask, then late enable of ch2
    do_reset(1);
    clear_logs();
    CH_ENABLE = 4'b1011;
    for (int k = 0; k < NCH; k++) load(k, 20, 3);
    for (int i = 0; i < 40; i++) tick();
    n2 = 0;
    foreach (grant_log[i]) if (grant_log[i] == 2) n2++;
    check_eq("t3_ch2_grants", n2, 0);
    check_eq("t3_ch2_reads", pop_cnt[2], 0);
    check_eq("t3_others_busy", int'(src_q[0].size() > 0 && src_q[1].size() > 0 && src_q[3].size() > 0), 1);
    CH_ENABLE[2] = 1'b1;
    got = 0;
    n = 0;
    while (got == 0 && n < NCH * (BM + 1) + 1) begin
      tick();
      n++;
      if (s_gv === 1'b1 && s_gch == 2'd2) got = 1;
    end
    check_eq("t3_ch2_granted", got, 1);
    drain("t3_drain", 400);
    check_eq("t3_words", out_cnt, 80);
    check_eq("t3_ch2_total", pop_cnt[2], 20);

    // Downstream stall for 20 cycles right after grant
    do_reset(1);
    clear_logs();
    OUT_READ = 1'b0;
    load(1, 8, 4);
    w0 = mk(1, 4, 0);
    tick();
    tick();
    check_eq("t4_first_rd", int'(s_rd), 2);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("t4_no_rd", int'(s_rd), 0);
      check_eq("t4_od_hold", int'(s_od), int'(w0));
      check_eq("t4_gch_hold", int'({s_gv, s_gch}), 5);
    end
    check_eq("t4_pops_stalled", pop_cnt[1], 1);
    OUT_READ = 1'b1;
    drain("t4_drain", 100);
    check_eq("t4_words", out_cnt, 8);
    check_eq("t4_pops", pop_cnt[1], 8);
    check_eq("t4_left", exp_q[1].size(), 0);

    // Counter saturation and clear-wins-over-pop
    do_reset(1);
    clear_logs();
    load(1, 20, 5);
    drain("t5_drain", 200);
    check_eq("t5_sat", cnt_of(WORD_CNT, 1), 15);
    check_eq("t5_cnt0", cnt_of(WORD_CNT, 0), 0);
    load(1, 3, 6);
    tick();
    tick();
    CNT_CLEAR = 1'b1;
    tick();
    check_eq("t5_clr_pop", int'(s_rd), 2);
    check_eq("t5_pre_clr", cnt_of(s_cnt, 1), 15);
    CNT_CLEAR = 1'b0;
    tick();
    check_eq("t5_after_clr", cnt_of(s_cnt, 1), 0);
    drain("t5_drain2", 50);
    check_eq("t5_final", cnt_of(WORD_CNT, 1), 1);

    // Reset mid-burst with a word held in the output register
    do_reset(1);
    clear_logs();
    load(2, 8, 7);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t6_pre_oe", int'(OUT_EMPTY), 0);
    check_eq("t6_pre_gv", int'(GRANT_VALID), 1);
    load(0, 4, 8);
    load(3, 4, 8);
    OUT_READ = 1'b0;
    do_reset(1);
    clear_logs();
    OUT_READ = 1'b1;
    tick();
    check_eq("t6_oe", int'(s_oe), 1);
    check_eq("t6_gv", int'(s_gv), 0);
    check_eq("t6_cnt", int'(s_cnt), 0);
    drain("t6_drain", 200);
    check_eq("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check_eq("t6_words", out_cnt, 13);
    for (int k = 0; k < NCH; k++) check_eq("t6_left", exp_q[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
